// File: rtl/psum_lif_spike_writer.sv
// psum_lif_spike_writer
//
// Converts the bias-added partial-sum stream into LIF spikes and writes the
// packed spike words into the downstream spike RAM. Each psum word holds
// TIME_STEPS signed slices for one neuron element. The element is carried
// through a pipeline with one stage per time step, and its spike nibble is
// packed into a DATA_WIDTH word. A full word is written every
// ELEMS_PER_WORD elements. After the stream ends, any partial word is
// flushed with its unfilled fields set to zero. The block sustains one
// element per cycle because the input stream has no back-pressure.
//
// Ports:
//   s_clk          clock
//   s_rst          synchronous active-high reset
//   i_PsumData     TIME_STEPS signed slices, slice t at [t*P_WIDTH +: P_WIDTH]
//   i_PsumValid    i_PsumData valid this cycle (no ready)
//   i_Psum_Finish  level, no further valid data once high
//   o_wr_en        spike RAM write strobe, one cycle per word
//   o_wr_addr      spike RAM write address
//   o_wr_data      packed spike word, element j at [j*TIME_STEPS +: TIME_STEPS]
//   o_busy         high from first accepted element until completion
//   o_done         sticky completion flag, cleared only by reset
module psum_lif_spike_writer #(
    parameter int unsigned TIME_STEPS = 4,
    parameter int unsigned P_WIDTH    = 20,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int          VTH        = 256,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                             s_clk,
    input  logic                             s_rst,
    input  logic [TIME_STEPS*P_WIDTH-1:0]    i_PsumData,
    input  logic                             i_PsumValid,
    input  logic                             i_Psum_Finish,
    output logic                             o_wr_en,
    output logic [ADDR_WIDTH-1:0]            o_wr_addr,
    output logic [DATA_WIDTH-1:0]            o_wr_data,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int unsigned ELEMS_PER_WORD = DATA_WIDTH / TIME_STEPS;
    localparam int unsigned CNT_W = (ELEMS_PER_WORD > 1) ? $clog2(ELEMS_PER_WORD) : 1;
    localparam int unsigned HW    = P_WIDTH + 2;
    localparam int unsigned XW    = TIME_STEPS * P_WIDTH;
    localparam logic signed [HW-1:0] VTH_H = HW'(VTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   flush_go;

    // Pipeline: index 0 is the input capture stage. Stage t holds the element
    // before time step t is evaluated. s_q[TIME_STEPS] holds the finished nibble.
    logic [XW-1:0]         x_q [TIME_STEPS];
    logic signed [HW-1:0]  v_q [TIME_STEPS];
    logic [TIME_STEPS-1:0] s_q [TIME_STEPS+1];
    logic [TIME_STEPS:0]   vld_q;

    logic [P_WIDTH-1:0]    sl_c   [TIME_STEPS];
    logic signed [HW-1:0]  xe_c   [TIME_STEPS];
    logic signed [HW-1:0]  diff_c [TIME_STEPS];
    logic signed [HW-1:0]  h_c    [TIME_STEPS];
    logic [TIME_STEPS-1:0] fire_c;
    logic [TIME_STEPS-1:0] s_c    [TIME_STEPS];

    // Packer / writer
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] pack_q;
    logic [DATA_WIDTH-1:0] pack_ins_c;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  last_elem;

    // ------------------------------------------------------------------
    // LIF step per stage: H = V + ((X - V) >>> 1), fire when H >= VTH.
    // ------------------------------------------------------------------
    always_comb begin
        fire_c = '0;
        for (int unsigned t = 0; t < TIME_STEPS; t++) begin
            sl_c[t]     = x_q[t][t*P_WIDTH +: P_WIDTH];
            xe_c[t]     = {{(HW-P_WIDTH){sl_c[t][P_WIDTH-1]}}, sl_c[t]};
            diff_c[t]   = xe_c[t] - v_q[t];
            h_c[t]      = v_q[t] + (diff_c[t] >>> 1);
            fire_c[t]   = (h_c[t] >= VTH_H);
            s_c[t]      = s_q[t];
            s_c[t][t]   = fire_c[t];
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            vld_q <= '0;
            for (int unsigned t = 0; t < TIME_STEPS; t++) begin
                x_q[t] <= '0;
                v_q[t] <= '0;
            end
            for (int unsigned t = 0; t <= TIME_STEPS; t++) begin
                s_q[t] <= '0;
            end
        end else begin
            vld_q  <= {vld_q[TIME_STEPS-1:0], accept};
            x_q[0] <= i_PsumData;
            v_q[0] <= '0;
            s_q[0] <= '0;
            for (int unsigned t = 1; t < TIME_STEPS; t++) begin
                x_q[t] <= x_q[t-1];
                v_q[t] <= fire_c[t-1] ? '0 : h_c[t-1];
            end
            for (int unsigned t = 1; t <= TIME_STEPS; t++) begin
                s_q[t] <= s_c[t-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Packing and RAM writes
    // ------------------------------------------------------------------
    always_comb begin
        pack_ins_c = pack_q;
        pack_ins_c[cnt_q*TIME_STEPS +: TIME_STEPS] = s_q[TIME_STEPS];
        last_elem  = (cnt_q == CNT_W'(ELEMS_PER_WORD - 1));
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            cnt_q      <= '0;
            pack_q     <= '0;
            addr_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (vld_q[TIME_STEPS]) begin
                if (last_elem) begin
                    wr_en_q    <= 1'b1;
                    wr_addr_q  <= addr_cnt_q;
                    wr_data_q  <= pack_ins_c;
                    addr_cnt_q <= addr_cnt_q + 1'b1;
                    pack_q     <= '0;
                    cnt_q      <= '0;
                end else begin
                    pack_q <= pack_ins_c;
                    cnt_q  <= cnt_q + 1'b1;
                end
            end else if (flush_go) begin
                // The pipeline is empty here, so a flush cannot collide with a full-word write.
                wr_en_q    <= 1'b1;
                wr_addr_q  <= addr_cnt_q;
                wr_data_q  <= pack_q;
                addr_cnt_q <= addr_cnt_q + 1'b1;
                pack_q     <= '0;
                cnt_q      <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_PsumValid) begin
                    accept  = 1'b1;
                    state_d = i_Psum_Finish ? S_DRAIN : S_RUN;
                end else if (i_Psum_Finish) begin
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                accept = i_PsumValid;
                if (i_Psum_Finish) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Empty pipeline means every full-word write has already been issued.
                if (vld_q == '0) begin
                    state_d = (cnt_q != '0) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // The flush write is registered on entry to S_FLUSH, so o_done follows one cycle later.
    assign flush_go  = (state_q == S_DRAIN) && (state_d == S_FLUSH);

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_busy    = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
    assign o_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_psum_lif_spike_writer.sv
// Testbench for psum_lif_spike_writer: table of constant-slice streams with
// known packed words, hand sequences for finish/reset/wrap corner cases,
// and a randomized stream checked against a behavioural LIF/packing model.
module tb_psum_lif_spike_writer;

    localparam int TS  = 4;
    localparam int PW  = 20;
    localparam int DW  = 64;
    localparam int AW  = 12;
    localparam int VTV = 256;
    localparam int EPW = DW / TS;

    logic              s_clk = 1'b0;
    logic              s_rst;
    logic [TS*PW-1:0]  i_PsumData;
    logic              i_PsumValid;
    logic              i_Psum_Finish;
    logic              o_wr_en;
    logic [AW-1:0]     o_wr_addr;
    logic [DW-1:0]     o_wr_data;
    logic              o_busy;
    logic              o_done;

    psum_lif_spike_writer #(
        .TIME_STEPS (TS),
        .P_WIDTH    (PW),
        .DATA_WIDTH (DW),
        .VTH        (VTV),
        .ADDR_WIDTH (AW)
    ) dut (
        .s_clk         (s_clk),
        .s_rst         (s_rst),
        .i_PsumData    (i_PsumData),
        .i_PsumValid   (i_PsumValid),
        .i_Psum_Finish (i_Psum_Finish),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 s_clk = ~s_clk;

    typedef int slices_t [TS];
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct {
        int          slice;
        bit          fin_last;
        logic [63:0] exp_data;
    } row_t;

    int            checks = 0;
    int            errors = 0;
    wr_t           exp_q[$];
    int            m_cnt;
    logic [DW-1:0] m_pack;
    logic [AW-1:0] m_addr;
    int            wr_count;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    logic [AW-1:0] addr_4097;
    wr_t           mon_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Floor division by 2 written arithmetically.
    function automatic int floor_half(input int d);
        if (d >= 0) return d / 2;
        return -((1 - d) / 2);
    endfunction

    function automatic logic [TS-1:0] ref_nibble(input slices_t x);
        logic [TS-1:0] n;
        int v, h;
        n = '0;
        v = 0;
        for (int t = 0; t < TS; t++) begin
            h = v + floor_half(x[t] - v);
            n[t] = (h >= VTV);
            v = n[t] ? 0 : h;
        end
        return n;
    endfunction

    function automatic void push_word(input logic [DW-1:0] data);
        wr_t w;
        w.addr = m_addr;
        w.data = data;
        exp_q.push_back(w);
        m_addr = m_addr + 1'b1;
        m_pack = '0;
        m_cnt  = 0;
    endfunction

    function automatic void model_push(input slices_t x);
        m_pack = m_pack | (DW'(ref_nibble(x)) << (m_cnt * TS));
        m_cnt++;
        if (m_cnt == EPW) push_word(m_pack);
    endfunction

    function automatic void model_flush();
        if (m_cnt != 0) push_word(m_pack);
    endfunction

    function automatic void model_reset();
        m_cnt  = 0;
        m_pack = '0;
        m_addr = '0;
    endfunction

    // Write monitor / scoreboard
    always @(negedge s_clk) begin
        if (o_wr_en === 1'b1) begin
            wr_count++;
            last_addr = o_wr_addr;
            last_data = o_wr_data;
            if (wr_count == 4097) addr_4097 = o_wr_addr;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%h data=%h required no write", o_wr_addr, o_wr_data);
            end else begin
                mon_w = exp_q.pop_front();
                chk("wr_addr", 64'(o_wr_addr), 64'(mon_w.addr));
                chk("wr_data", o_wr_data, mon_w.data);
            end
        end
    end

    task automatic send(input slices_t x, input bit fin, input bit modeled);
        @(negedge s_clk);
        i_PsumValid   = 1'b1;
        i_Psum_Finish = fin;
        for (int t = 0; t < TS; t++) i_PsumData[t*PW +: PW] = x[t][PW-1:0];
        if (modeled) model_push(x);
    endtask

    task automatic send_const(input int v, input int n, input bit modeled);
        slices_t x;
        for (int t = 0; t < TS; t++) x[t] = v;
        for (int i = 0; i < n; i++) send(x, 1'b0, modeled);
    endtask

    task automatic idle_cycle();
        @(negedge s_clk);
        i_PsumValid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wr_en"},   64'(o_wr_en),   64'd0);
        chk({tag, "_wr_addr"}, 64'(o_wr_addr), 64'd0);
        chk({tag, "_wr_data"}, o_wr_data,      64'd0);
        chk({tag, "_busy"},    64'(o_busy),    64'd0);
        chk({tag, "_done"},    64'(o_done),    64'd0);
    endtask

    task automatic do_reset();
        @(negedge s_clk);
        chk("pending_before_reset", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        i_PsumValid   = 1'b0;
        i_Psum_Finish = 1'b0;
        s_rst         = 1'b1;
        @(negedge s_clk);
        check_zero_outputs("reset");
        s_rst = 1'b0;
        model_reset();
        wr_count = 0;
    endtask

    task automatic wait_done();
        int n;
        @(negedge s_clk);
        i_PsumValid   = 1'b0;
        i_Psum_Finish = 1'b1;
        model_flush();
        n = 0;
        while (o_done !== 1'b1 && n < 100) begin
            @(negedge s_clk);
            n++;
        end
        chk("done_raised", 64'(o_done), 64'd1);
        chk("busy_cleared", 64'(o_busy), 64'd0);
        @(negedge s_clk);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        row_t    rows[4];
        slices_t x;
        int      lat;
        int      n;

        s_rst         = 1'b1;
        i_PsumValid   = 1'b0;
        i_Psum_Finish = 1'b0;
        i_PsumData    = '0;
        wr_count      = 0;
        model_reset();
        repeat (2) @(negedge s_clk);

        rows[0] = '{512,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        rows[1] = '{300,   1'b0, 64'h4444_4444_4444_4444};
        rows[2] = '{-1000, 1'b0, 64'h0000_0000_0000_0000};
        rows[3] = '{512,   1'b1, 64'hFFFF_FFFF_FFFF_FFFF};

        // Table: one full word of constant slices, latency and packed data.
        foreach (rows[r]) begin
            do_reset();
            for (int t = 0; t < TS; t++) x[t] = rows[r].slice;
            for (int e = 0; e < EPW; e++) send(x, rows[r].fin_last && (e == EPW - 1), 1'b1);
            idle_cycle();
            chk("busy_running", 64'(o_busy), 64'd1);
            lat = 0;
            while (lat < 20) begin
                @(posedge s_clk);
                lat++;
                @(negedge s_clk);
                if (o_wr_en === 1'b1) break;
            end
            chk("wr_latency", 64'(lat), 64'd5);
            chk("row_data", o_wr_data, rows[r].exp_data);
            chk("row_addr", 64'(o_wr_addr), 64'd0);
            if (rows[r].fin_last) begin
                wait_done();
                chk("no_flush_write_count", 64'(wr_count), 64'd1);
            end
        end

        // 40 elements then finish: two full words and a half-filled flush.
        do_reset();
        send_const(512, 40, 1'b1);
        wait_done();
        chk("flush_write_count", 64'(wr_count), 64'd3);
        chk("flush_addr", 64'(last_addr), 64'd2);
        chk("flush_data", last_data, 64'h0000_0000_FFFF_FFFF);
        // Done is sticky and later valids are ignored.
        i_Psum_Finish = 1'b0;
        send_const(512, 20, 1'b0);
        idle_cycle();
        repeat (10) @(negedge s_clk);
        chk("after_done_writes", 64'(wr_count), 64'd3);
        chk("done_sticky", 64'(o_done), 64'd1);

        // Finish in idle with no data.
        do_reset();
        wait_done();
        chk("idle_finish_writes", 64'(wr_count), 64'd0);

        // Reset while elements are in flight.
        do_reset();
        send_const(512, 16, 1'b1);
        send_const(512, 5, 1'b0);
        @(negedge s_clk);
        i_PsumValid = 1'b0;
        s_rst       = 1'b1;
        @(negedge s_clk);
        check_zero_outputs("midrst");
        s_rst = 1'b0;
        chk("pre_reset_writes", 64'(wr_count), 64'd1);
        chk("pre_reset_pending", 64'(exp_q.size()), 64'd0);
        model_reset();
        wr_count = 0;
        repeat (10) @(negedge s_clk);
        chk("post_reset_no_write", 64'(wr_count), 64'd0);
        send_const(512, 16, 1'b1);
        idle_cycle();
        n = 0;
        while (wr_count == 0 && n < 20) begin
            @(negedge s_clk);
            n++;
        end
        chk("fresh_write_count", 64'(wr_count), 64'd1);
        chk("fresh_addr", 64'(last_addr), 64'd0);
        chk("fresh_data", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done();

        // Randomized stream with gaps and extreme values.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            for (int t = 0; t < TS; t++) begin
                case ($urandom_range(0, 9))
                    0:       x[t] = -(2 ** (PW - 1));
                    1:       x[t] = (2 ** (PW - 1)) - 1;
                    default: x[t] = int'($urandom_range(0, 1400)) - 500;
                endcase
            end
            send(x, 1'b0, 1'b1);
        end
        wait_done();
        chk("random_write_count", 64'(wr_count), 64'((200 + EPW - 1) / EPW));

        // Address wrap: the 4097th write returns to address 0.
        do_reset();
        send_const(512, 16 * 4096 + 16, 1'b1);
        wait_done();
        chk("wrap_write_count", 64'(wr_count), 64'd4097);
        chk("wrap_addr_4097", 64'(addr_4097), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_lif_spike_writer.md
Name: psum_lif_spike_writer

Overview:
Receives the bias-added partial-sum stream from the systolic controller (o_PsumData/o_PsumValid/o_Psum_Finish) and turns each packed psum word into spikes with a pipelined LIF neuron across TIME_STEPS.
Packs the spike nibbles into DATA_WIDTH words and writes them sequentially into the downstream spike RAM.
Signals completion once the final partial word is flushed.
The stream has no back-pressure, so the block must sustain one psum word per cycle.

Parameters:
TIME_STEPS, 4, time steps packed per psum word
P_WIDTH, 20, signed width of one time-step psum (SYSTOLIC_PSUM_WIDTH / TIME_STEPS)
DATA_WIDTH, 64, spike RAM word width; ELEMS_PER_WORD = DATA_WIDTH / TIME_STEPS = 16 (derived)
VTH, 256, firing threshold, signed, same scale as psum
ADDR_WIDTH, 12, spike RAM address width

Ports:
s_clk  in  1  clock
s_rst  in  1  synchronous active-high reset
i_PsumData  in  TIME_STEPS*P_WIDTH  slice t = bits [t*P_WIDTH +: P_WIDTH], signed psum of time step t
i_PsumValid  in  1  i_PsumData valid this cycle; no ready
i_Psum_Finish  in  1  level; once high, no further valid data follows
o_wr_en  out  1  spike RAM write strobe, one cycle per word
o_wr_addr  out  ADDR_WIDTH  spike RAM write address
o_wr_data  out  DATA_WIDTH  packed spike word
o_busy  out  1  high from first accepted valid until o_done
o_done  out  1  sticky completion flag

Behaviour:
- Clocking and reset: one clock, s_clk. Reset is synchronous, active-high, on s_rst.
- Reset values: all outputs 0; address counter 0; pack counter 0; pipeline valids 0; FSM in S_IDLE. A reset mid-stream discards pipeline contents and any partial word, with no write.
- LIF per element, membrane V starts at 0 for every element:
  - For t = 0..TIME_STEPS-1: H = V + ((X_t - V) >>> 1), using arithmetic shift and computed at P_WIDTH+2 signed bits with X_t sign-extended.
  - s_t = (H >= VTH). V <= s_t ? 0 : H.
- Pipeline: one register stage per time step. Each stage carries V, a valid bit, the remaining psum slices and the spike bits gathered so far. The nibble for an element accepted at edge k is complete at edge k+TIME_STEPS.
- Packing:
  - Element j of a word occupies o_wr_data[j*TIME_STEPS +: TIME_STEPS]; bit t within that field is s_t.
  - Elements fill in arrival order, j = 0 first.
  - When element 15 lands, o_wr_en pulses on the next edge, i.e. TIME_STEPS+1 edges after that element's valid.
  - The pack counter returns to 0 and o_wr_addr increments after the write, wrapping modulo 2^ADDR_WIDTH.
- FSM:
  - S_IDLE: move to S_RUN on i_PsumValid.
  - S_RUN: accept every valid. On i_Psum_Finish high, move to S_DRAIN.
  - S_DRAIN: wait until all pipeline valids are 0 and the last full-word write is issued. Go to S_FLUSH if the pack counter != 0, else S_DONE.
  - S_FLUSH: write the partial word with unfilled fields zero, for one o_wr_en pulse, then go to S_DONE.
  - S_DONE: o_done=1, o_busy=0. Hold until reset. i_PsumValid is ignored.
- i_Psum_Finish is a level; only its first observation in S_RUN acts. i_Psum_Finish seen in S_IDLE with no data goes straight to S_DONE with no write.
- If i_PsumValid and i_Psum_Finish are high in the same cycle, that word is accepted, then the FSM drains.
- Back-to-back valids need no bubble. Throughput is one element per cycle; a full word is written every 16 valids.

Test Plan:
- Reset, then 16 valids with every slice = 512 -> first o_wr_en 5 edges after the 16th valid, at addr 0. Each nibble = 4'b1111, since H=256 >= VTH, V resets to 0 and every step fires. o_wr_data = 64'hFFFF_FFFF_FFFF_FFFF.
- 16 valids with every slice = 300 -> H sequence 150, 225, 262, 150 gives nibble 4'b0100 and o_wr_data = 64'h4444_4444_4444_4444. 16 valids with every slice = -1000 -> 64'h0.
- 40 consecutive valids of 512 then i_Psum_Finish -> writes at addr 0 and 1 (all F), then a flush at addr 2 with data 64'h0000_0000_FFFF_FFFF. o_done rises after the flush and stays high; later valids produce no writes.
- 16*4096+16 valids -> address wraps, and the 4097th write lands at addr 0.
- i_PsumValid and i_Psum_Finish high together on the 16th word -> that word is written, with no flush write. Finish in S_IDLE with no data -> o_done=1, zero writes.
- s_rst asserted while 5 elements are in flight -> no write; outputs zero on the next edge. A fresh 16-word stream then writes at addr 0.
